// File: rtl/mp1_mem_pkg.sv
// Shared types and widths for the mp1 fixed-latency memory responder.
package mp1_mem_pkg;

   localparam int WORD_W = 32;
   localparam int LANE_W = 8;
   localparam int LANES  = WORD_W / LANE_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_t;

endpackage

// File: rtl/mp1_mem_array.sv
// Single-port word array with per-byte write mask and registered read data.
module mp1_mem_array
   import mp1_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic                  re,
   input  logic [LANES-1:0]      wmask,
   input  logic [ADDR_WIDTH-1:0] idx,
   input  logic [WORD_W-1:0]     wdata,
   output logic [WORD_W-1:0]     rdata
);

   logic [WORD_W-1:0] mem [2**ADDR_WIDTH];

   // Contents are deliberately not reset; only the read register is.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < LANES; i++) begin
            if (wmask[i]) mem[idx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
         end
      end
   end

   // rdata only moves on a read, so it holds the last read word otherwise.
   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[idx];
   end

endmodule

// File: rtl/mp1_mem_ctrl.sv
// Fixed-latency memory responder for the mp1 core memory port, with sticky protocol error.
module mp1_mem_ctrl
   import mp1_mem_pkg::*;
#(
   parameter int LATENCY    = 3,
   parameter int ADDR_WIDTH = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       mem_address,
   input  logic [WORD_W-1:0] mem_wdata,
   input  logic [LANES-1:0]  mem_byte_enable,
   output logic              mem_resp,
   output logic [WORD_W-1:0] mem_rdata,
   output logic              err
);

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_t                state;
   op_t                   op;
   logic [3:0]            cnt;
   logic [ADDR_WIDTH-1:0] idx;
   logic [WORD_W-1:0]     wdata_q;
   logic [LANES-1:0]      be_q;
   logic                  fire;
   logic                  unused_addr;

   assign unused_addr = ^{mem_address[31:ADDR_WIDTH+2], mem_address[1:0]};

   // The access lands on the BUSY->RESP edge; a reset on that edge drops it.
   assign fire = (state == BUSY) && (cnt == 4'd0) && !rst;

   mp1_mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (fire && (op == OP_WRITE)),
      .re    (fire && (op == OP_READ)),
      .wmask (be_q),
      .idx   (idx),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         mem_resp <= 1'b0;
         err      <= 1'b0;
      end else begin
         mem_resp <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_read && mem_write) begin
                  err <= 1'b1;
               end else if (mem_read || mem_write) begin
                  idx     <= mem_address[ADDR_WIDTH+1:2];
                  wdata_q <= mem_wdata;
                  be_q    <= mem_byte_enable;
                  op      <= mem_write ? OP_WRITE : OP_READ;
                  cnt     <= LAT_M1;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
               else             state <= RESP;
            end
            RESP: begin
               // Registered pulse: visible in the cycle after RESP, LATENCY+1 after capture.
               mem_resp <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mp1_mem_ctrl.sv
// Directed bench for mp1_mem_ctrl (LATENCY=3, ADDR_WIDTH=10).
module tb_mp1_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] mem_address = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_byte_enable = '0;
   logic        mem_resp;
   logic [31:0] mem_rdata;
   logic        err;

   int errors = 0;
   int checks = 0;

   mp1_mem_ctrl #(.LATENCY(3), .ADDR_WIDTH(10)) dut (
      .clk             (clk),
      .rst             (rst),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_resp        (mem_resp),
      .mem_rdata       (mem_rdata),
      .err             (err)
   );

   always #5 clk = ~clk;

   // Issue one request; lat = edges after capture until mem_resp seen (-1 on timeout),
   // after = mem_resp one cycle after the pulse.
   task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd, output int lat,
                         output logic after);
      lat = -1;
      rd = '0;
      after = 1'bx;
      @(posedge clk); #1;
      mem_read = !wr; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; mem_wdata = 32'h0BAD_0BAD; mem_byte_enable = 4'hF;
      for (int i = 1; i <= 20; i++) begin
         if (i > 1) begin @(posedge clk); #1; end
         if (mem_resp) begin lat = i; break; end
         if (i == 1) begin @(posedge clk); #1; if (mem_resp) begin lat = 2; break; end end
      end
      if (lat > 0) begin
         rd = mem_rdata;
         @(posedge clk); #1;
         after = mem_resp;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b want 0", mem_resp); end
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", mem_rdata); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      rst = 1'b0;
   endtask

   task automatic test_write_read;
      logic [31:0] rd; int lat; logic after;
      access(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, rd, lat, after);
      checks++; if (lat !== 4) begin errors++; $display("FAIL wr_latency: got %0d want 4", lat); end
      checks++; if (after !== 1'b0) begin errors++; $display("FAIL wr_pulse_width: got %b want 0", after); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata_unchanged: got %h want 0", rd); end
      access(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, lat, after);
      checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency: got %0d want 4", lat); end
      checks++; if (after !== 1'b0) begin errors++; $display("FAIL rd_pulse_width: got %b want 0", after); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
   endtask

   task automatic test_partial_write;
      logic [31:0] rd; int lat; logic after;
      access(1'b1, 32'h0000_0010, 32'h0000_AA00, 4'b0010, rd, lat, after);
      access(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, lat, after);
      checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL partial_lane1: got %h want deadaaef", rd); end
      access(1'b1, 32'h0000_0010, 32'h5555_5555, 4'b0000, rd, lat, after);
      checks++; if (lat !== 4) begin errors++; $display("FAIL be0_handshake: got %0d want 4", lat); end
      access(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, lat, after);
      checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL be0_no_change: got %h want deadaaef", rd); end
   endtask

   task automatic test_alias;
      logic [31:0] rd; int lat; logic after;
      access(1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, rd, lat, after);
      access(1'b0, 32'h0000_1004, 32'h0, 4'h0, rd, lat, after);
      checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL alias_upper: got %h want 12345678", rd); end
      access(1'b0, 32'h0000_0007, 32'h0, 4'h0, rd, lat, after);
      checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL alias_low_bits: got %h want 12345678", rd); end
   endtask

   task automatic test_back_to_back;
      int pulses[$];
      int unstable = 0;
      @(posedge clk); #1;
      mem_read = 1'b1; mem_address = 32'h0000_0010;
      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #1;
         if (mem_resp) pulses.push_back(i);
         if (i >= 4 && mem_rdata !== 32'hDEADAAEF) unstable++;
         if (i == 14) mem_read = 1'b0;
      end
      checks++; if (pulses.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", pulses.size()); end
      if (pulses.size() == 3) begin
         checks++; if (pulses[0] != 4) begin errors++; $display("FAIL b2b_first: got %0d want 4", pulses[0]); end
         checks++; if (pulses[1] - pulses[0] != 5) begin errors++; $display("FAIL b2b_gap1: got %0d want 5", pulses[1] - pulses[0]); end
         checks++; if (pulses[2] - pulses[1] != 5) begin errors++; $display("FAIL b2b_gap2: got %0d want 5", pulses[2] - pulses[1]); end
      end
      checks++; if (unstable != 0) begin errors++; $display("FAIL b2b_rdata_stable: got %0d bad samples want 0", unstable); end
   endtask

   task automatic test_protocol_error;
      logic [31:0] rd; int lat; logic after;
      int stray = 0;
      @(posedge clk); #1;
      mem_read = 1'b1; mem_write = 1'b1; mem_address = 32'h0000_0010; mem_wdata = 32'hFFFF_FFFF;
      mem_byte_enable = 4'hF;
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err); end
      for (int i = 0; i < 6; i++) begin
         if (mem_resp) stray++;
         @(posedge clk); #1;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL err_no_resp: got %0d pulses want 0", stray); end
      access(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, lat, after);
      checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL err_no_access: got %h want deadaaef", rd); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL err_then_read: got %0d want 4", lat); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
   endtask

   task automatic test_reset_mid_op;
      logic [31:0] rd; int lat; logic after;
      int stray = 0;
      access(1'b1, 32'h0000_0020, 32'h0000_0000, 4'hF, rd, lat, after);
      @(posedge clk); #1;
      mem_write = 1'b1; mem_address = 32'h0000_0020; mem_wdata = 32'h1111_1111; mem_byte_enable = 4'hF;
      @(posedge clk); #1;
      mem_write = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL mid_rst_resp: got %b want 0", mem_resp); end
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL mid_rst_rdata: got %h want 0", mem_rdata); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b want 0", err); end
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (mem_resp) stray++;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL mid_rst_no_resp: got %0d pulses want 0", stray); end
      access(1'b0, 32'h0000_0020, 32'h0, 4'h0, rd, lat, after);
      checks++; if (lat !== 4) begin errors++; $display("FAIL mid_rst_read_lat: got %0d want 4", lat); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_rst_dropped: got %h want 0", rd); end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_partial_write;
      test_alias;
      test_back_to_back;
      test_protocol_error;
      test_reset_mid_op;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
